mul_float_arbiter: RTL and testbench

- Shares one pipelined single-precision float multiplier (valid/busy handshake, in-order results) among P_N requesters.
- Round-robin arbitration picks one operand pair per cycle and registers it toward the multiplier.
- Records the winner's ID in a tag FIFO and routes each returning result back to the requester that issued it.
- Sits between the execution-unit request ports and the multiplier pipeline.

---
 rtl/mul_float_arbiter_if.sv | 34 +++
 rtl/mul_float_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mul_float_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_float_arbiter_if.sv
// Handshake bundle between mul_float_arbiter, its requesters and the shared float multiplier.
// master = arbiter side, slave = the surrounding requesters/multiplier.
interface mul_float_arbiter_if #(
  parameter int P_N = 4
);
  logic [P_N-1:0]    iREQ_VALID;
  logic [P_N-1:0]    oREQ_BUSY;
  logic [P_N*32-1:0] iREQ_A;
  logic [P_N*32-1:0] iREQ_B;

  logic              oMUL_VALID;
  logic              iMUL_BUSY;
  logic [31:0]       oMUL_A;
  logic [31:0]       oMUL_B;

  logic              iMUL_VALID;
  logic              oMUL_BUSY;
  logic [31:0]       iMUL_DATA;

  logic [P_N-1:0]    oRES_VALID;
  logic [P_N-1:0]    iRES_BUSY;
  logic [31:0]       oRES_DATA;
  logic              oERROR;

  modport master (
    input  iREQ_VALID, iREQ_A, iREQ_B, iMUL_BUSY, iMUL_VALID, iMUL_DATA, iRES_BUSY,
    output oREQ_BUSY, oMUL_VALID, oMUL_A, oMUL_B, oMUL_BUSY, oRES_VALID, oRES_DATA, oERROR
  );

  modport slave (
    output iREQ_VALID, iREQ_A, iREQ_B, iMUL_BUSY, iMUL_VALID, iMUL_DATA, iRES_BUSY,
    input  oREQ_BUSY, oMUL_VALID, oMUL_A, oMUL_B, oMUL_BUSY, oRES_VALID, oRES_DATA, oERROR
  );
endinterface

// File: rtl/mul_float_arbiter.sv
// Shares one pipelined float multiplier among P_N requesters and routes results back by tag.
// Define MUL_FLOAT_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mul_float_arbiter #(
  parameter int P_N     = 4,
  parameter int P_DEPTH = 8,
  parameter int P_TAGW  = 2
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRESET_SYNC,
  mul_float_arbiter_if.master bus
);

  localparam int LP_PTRW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int LP_CNTW = $clog2(P_DEPTH + 1);

  logic              mulValid_q, mulValid_d;
  logic [31:0]       mulA_q, mulA_d;
  logic [31:0]       mulB_q, mulB_d;
  logic [LP_PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [LP_PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [LP_CNTW-1:0] count_q, count_d;
  logic              error_q, error_d;
  logic [P_TAGW-1:0] tags_q [P_DEPTH];

  logic [P_TAGW-1:0] head;
  logic [P_TAGW-1:0] grantId;
  logic [P_TAGW-1:0] cand;
  logic              grantFound;
  logic              grant;
  logic              issueFree;
  logic              canIssue;
  logic              fifoEmpty;
  logic              push;
  logic              pop;

  assign head      = tags_q[rdPtr_q];
  assign fifoEmpty = (count_q == '0);
  assign issueFree = !mulValid_q || !bus.iMUL_BUSY;
  // A same-cycle pop never frees a slot early; no grants during a synchronous clear.
  assign canIssue  = issueFree && (count_q < LP_CNTW'(P_DEPTH)) && !iRESET_SYNC;
  assign grant     = canIssue && grantFound;
  assign push      = grant;
  assign pop       = bus.iMUL_VALID && !fifoEmpty && !bus.iRES_BUSY[head];

`ifdef MUL_FLOAT_ARBITER_FIXED_PRIO_EN
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    cand       = '0;
    for (int k = P_N - 1; k >= 0; k--) begin
      cand = P_TAGW'(k);
      if (bus.iREQ_VALID[cand]) begin
        grantFound = 1'b1;
        grantId    = cand;
      end
    end
  end
`else
  logic [P_TAGW-1:0] rrPtr_q, rrPtr_d;

  // Descending scan so the candidate closest to the pointer is the last one to win.
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    cand       = '0;
    for (int k = P_N - 1; k >= 0; k--) begin
      cand = P_TAGW'((int'(rrPtr_q) + k) % P_N);
      if (bus.iREQ_VALID[cand]) begin
        grantFound = 1'b1;
        grantId    = cand;
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grant) begin
      rrPtr_d = (grantId == P_TAGW'(P_N - 1)) ? '0 : grantId + 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rrPtr_q <= '0;
    end else if (iRESET_SYNC) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`endif

  always_comb begin
    bus.oREQ_BUSY = '1;
    if (grant) begin
      bus.oREQ_BUSY[grantId] = 1'b0;
    end
  end

  always_comb begin
    mulValid_d = mulValid_q;
    mulA_d     = mulA_q;
    mulB_d     = mulB_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    error_d    = error_q;
    if (issueFree) begin
      mulValid_d = grant;
    end
    if (grant) begin
      mulA_d = bus.iREQ_A[32*grantId +: 32];
      mulB_d = bus.iREQ_B[32*grantId +: 32];
    end
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A result with no tag outstanding has nowhere to go; it is dropped and flagged.
    if (bus.iMUL_VALID && fifoEmpty) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mulValid_q <= 1'b0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else if (iRESET_SYNC) begin
      mulValid_q <= 1'b0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      mulValid_q <= mulValid_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      error_q    <= error_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      tags_q[wrPtr_q] <= grantId;
    end
  end

  assign bus.oMUL_VALID = mulValid_q;
  assign bus.oMUL_A     = mulA_q;
  assign bus.oMUL_B     = mulB_q;
  assign bus.oERROR     = error_q;
  assign bus.oRES_DATA  = bus.iMUL_DATA;
  assign bus.oMUL_BUSY  = !fifoEmpty && bus.iRES_BUSY[head];
  assign bus.oRES_VALID = (bus.iMUL_VALID && !fifoEmpty) ? ({{(P_N-1){1'b0}}, 1'b1} << head) : '0;

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Scoreboard bench for mul_float_arbiter: directed requester traffic against a behavioural
// multiplier model with programmable latency; results are checked as they leave the arbiter.
module tb_mul_float_arbiter;

  localparam int N = 4;

  typedef struct {
    int          id;
    logic [31:0] data;
  } expT;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mulT;

  logic clock = 1'b0;
  logic resetN;
  logic resetSync;

  int checks   = 0;
  int failures = 0;
  int mulLat   = 3;
  int cyc      = 0;

  logic        injectValid = 1'b0;
  logic [31:0] injectData  = '0;

  logic [31:0] opA     [N] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'hC0000000};
  logic [31:0] opB     [N] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3FC00000};
  logic [31:0] expProd [N] = '{32'h40400000, 32'h40800000, 32'h3FC00000, 32'hC0400000};

  expT sbQ  [$];
  mulT mulQ [$];

  always #5 clock = ~clock;

  mul_float_arbiter_if #(.P_N(N)) bus ();

  mul_float_arbiter #(
    .P_N    (N),
    .P_DEPTH(8),
    .P_TAGW (2)
  ) dut (
    .iCLOCK     (clock),
    .inRESET    (resetN),
    .iRESET_SYNC(resetSync),
    .bus        (bus)
  );

  // Truncating float32 multiply for normal operands; enough for the exact products used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] resBusy, input logic sync);
    @(posedge clock);
    #1;
    bus.iREQ_VALID = valid;
    bus.iRES_BUSY  = resBusy;
    resetSync      = sync;
  endtask

  task automatic resetDut();
    resetN         = 1'b0;
    resetSync      = 1'b0;
    injectValid    = 1'b0;
    bus.iREQ_VALID = '0;
    bus.iRES_BUSY  = '0;
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b1;
    @(negedge clock);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_remaining", sbQ.size(), 32'd0);
  endtask

  // Multiplier model: presents the oldest due result, holds it while the arbiter stalls.
  always @(posedge clock) begin
    #2;
    cyc++;
    if (mulQ.size() > 0 && mulQ[0].due <= cyc) begin
      bus.iMUL_VALID = 1'b1;
      bus.iMUL_DATA  = mulQ[0].data;
    end else if (injectValid) begin
      bus.iMUL_VALID = 1'b1;
      bus.iMUL_DATA  = injectData;
    end else begin
      bus.iMUL_VALID = 1'b0;
      bus.iMUL_DATA  = '0;
    end
  end

  always @(negedge clock) begin
    if (!resetN || resetSync) begin
      mulQ.delete();
    end else begin
      if (bus.iMUL_VALID && !bus.oMUL_BUSY && mulQ.size() > 0 && mulQ[0].due <= cyc) begin
        void'(mulQ.pop_front());
      end
      if (bus.oMUL_VALID && !bus.iMUL_BUSY) begin
        mulQ.push_back('{data: fmul(bus.oMUL_A, bus.oMUL_B), due: cyc + mulLat});
      end
    end
  end

  // Requester side: every accepted operation expects its own hand-computed product back.
  always @(negedge clock) begin
    if (!resetN || resetSync) begin
      sbQ.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.iREQ_VALID[i] && !bus.oREQ_BUSY[i]) begin
          sbQ.push_back('{id: i, data: expProd[i]});
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every delivered result.
  always @(negedge clock) begin
    expT e;
    if (resetN && !resetSync && bus.oRES_VALID != '0) begin
      if (!$onehot(bus.oRES_VALID)) begin
        checkOutput("res_onehot", 32'(bus.oRES_VALID), 32'd0);
      end else if ((bus.oRES_VALID & ~bus.iRES_BUSY) != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("res_unexpected", 32'(bus.oRES_VALID), 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("res_route", 32'(bus.oRES_VALID), 32'd1 << e.id);
          checkOutput("res_data", bus.oRES_DATA, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  grants;
    bit  popSeen;
    bit  found;

    resetN        = 1'b0;
    resetSync     = 1'b0;
    bus.iMUL_BUSY = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.iREQ_A[32*i +: 32] = opA[i];
      bus.iREQ_B[32*i +: 32] = opB[i];
    end

    // Reset state and a single operation from requester 0.
    resetDut();
    checkOutput("rst_mul_valid", 32'(bus.oMUL_VALID), 32'd0);
    checkOutput("rst_req_busy", 32'(bus.oREQ_BUSY), 32'hF);
    checkOutput("rst_res_valid", 32'(bus.oRES_VALID), 32'd0);
    checkOutput("rst_error", 32'(bus.oERROR), 32'd0);
    checkOutput("rst_count", 32'(dut.count_q), 32'd0);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t1_grant", 32'(bus.oREQ_BUSY), 32'hE);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t1_mul_valid", 32'(bus.oMUL_VALID), 32'd1);
    checkOutput("t1_mul_a", bus.oMUL_A, 32'h3FC00000);
    checkOutput("t1_mul_b", bus.oMUL_B, 32'h40000000);
    waitDrain(50);
    @(posedge clock);
    @(negedge clock);
    checkOutput("t1_count_idle", 32'(dut.count_q), 32'd0);

    // All requesters valid: one grant per cycle in round-robin order.
    resetDut();
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checkOutput("t2_rr_grant", 32'(bus.iREQ_VALID & ~bus.oREQ_BUSY), 32'd1 << (k % 4));
      if (k < 7) begin
        @(posedge clock);
        #1;
      end
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    waitDrain(60);

    // Long multiplier latency: eight in flight, then stall through the first pop.
    resetDut();
    mulLat = 20;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    grants  = 0;
    popSeen = 1'b0;
    for (int k = 0; k < 60 && !popSeen; k++) begin
      @(negedge clock);
      if (bus.iMUL_VALID && !bus.oMUL_BUSY) begin
        popSeen = 1'b1;
        checkOutput("t3_grants_before_pop", grants, 32'd8);
        checkOutput("t3_busy_in_pop_cycle", 32'(bus.oREQ_BUSY), 32'hF);
        checkOutput("t3_count_full", 32'(dut.count_q), 32'd8);
      end else begin
        if ((bus.iREQ_VALID & ~bus.oREQ_BUSY) != '0) grants++;
        @(posedge clock);
        #1;
      end
    end
    if (!popSeen) failNow("t3_first_pop");
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("t3_grant_after_pop", 32'(bus.iREQ_VALID & ~bus.oREQ_BUSY), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    waitDrain(100);

    // Requester 2 stalls its result; everything behind it waits.
    resetDut();
    mulLat = 3;
    applyStimulus(4'b1111, 4'b0100, 1'b0);
    repeat (3) @(posedge clock);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (bus.oRES_VALID[2]) found = 1'b1;
    end
    if (!found) begin
      failNow("t4_head_req2");
    end else begin
      for (int s = 0; s < 5; s++) begin
        if (s > 0) @(negedge clock);
        checkOutput("t4_hol_busy", 32'(bus.oMUL_BUSY), 32'd1);
        checkOutput("t4_hol_valid", 32'(bus.oRES_VALID), 32'h4);
        checkOutput("t4_hol_data", bus.oRES_DATA, 32'h3FC00000);
        @(posedge clock);
        #1;
      end
    end
    bus.iRES_BUSY = '0;
    waitDrain(40);

    // Orphan result with nothing outstanding.
    resetDut();
    @(posedge clock);
    #1;
    injectValid = 1'b1;
    injectData  = 32'h12345678;
    @(negedge clock);
    checkOutput("t5_orphan_res_valid", 32'(bus.oRES_VALID), 32'd0);
    checkOutput("t5_orphan_mul_busy", 32'(bus.oMUL_BUSY), 32'd0);
    @(posedge clock);
    #1;
    injectValid = 1'b0;
    @(negedge clock);
    checkOutput("t5_error_set", 32'(bus.oERROR), 32'd1);
    repeat (4) @(negedge clock);
    checkOutput("t5_error_sticky", 32'(bus.oERROR), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    @(negedge clock);
    checkOutput("t5_error_before_clear", 32'(bus.oERROR), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t5_error_cleared", 32'(bus.oERROR), 32'd0);

    // Synchronous clear with three operations in flight.
    resetDut();
    mulLat = 20;
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("t6_issue", 32'(bus.iREQ_VALID & ~bus.oREQ_BUSY), 32'd1 << k);
      if (k < 2) begin
        @(posedge clock);
        #1;
      end
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t6_mul_valid", 32'(bus.oMUL_VALID), 32'd0);
    checkOutput("t6_count", 32'(dut.count_q), 32'd0);
    checkOutput("t6_res_valid", 32'(bus.oRES_VALID), 32'd0);
    applyStimulus(4'b1010, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t6_grant_req1", 32'(bus.oREQ_BUSY), 32'hD);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("t6_grant_req3", 32'(bus.oREQ_BUSY), 32'h7);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    waitDrain(100);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
